// File: rtl/counter_sched_pkg.sv
// counter_sched_pkg: state encoding, requester count, default width and owner one-hot helper for counter_scheduler
package counter_sched_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int NUM_REQ = 2;
  localparam int DEF_WIDTH = 8;
  function automatic logic [NUM_REQ-1:0] owner_oh(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/counter_scheduler_tick_gen.sv
// tick_gen: count-enable prescaler (clk, reset active-low async, clear, freeze -> one-cycle tick every PRESCALE unfrozen cycles)
module tick_gen #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic freeze,
  output logic tick
);
  localparam int CW = $clog2(PRESCALE);
  logic [CW-1:0] cnt_q, cnt_d;
  logic wrap;
  always_comb begin
    wrap  = cnt_q == CW'(PRESCALE - 1);
    cnt_d = clear ? '0 : freeze ? cnt_q : wrap ? '0 : cnt_q + CW'(1);
    tick  = wrap && !freeze && !clear;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/counter_scheduler.sv
// counter_scheduler: round-robin timeshare of one up-counter (clk, reset active-low async, req, tc0, tc1, hold -> gnt, busy, count, done); COUNTER_PRESCALE_EN adds a tick_gen prescaler
module counter_scheduler
  import counter_sched_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESCALE = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [WIDTH-1:0]   tc0,
  input  logic [WIDTH-1:0]   tc1,
  input  logic               hold,
  output logic [NUM_REQ-1:0] gnt,
  output logic               busy,
  output logic [WIDTH-1:0]   count,
  output logic [NUM_REQ-1:0] done
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] tc_q, tc_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             winner;
  logic             tick;
  if (PRESCALE < 2) begin : g_bad_prescale
    $error("PRESCALE must be at least 2");
  end
`ifdef COUNTER_PRESCALE_EN
  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == IDLE && |req),
    .freeze (hold),
    .tick   (tick)
  );
`else
  assign tick = 1'b1;
`endif
  assign winner = &req ? ~last_q : req[1];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      tc_q    <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = tc_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE:
        if (|req) begin
          state_d = RUN;
          owner_d = winner;
          tc_d    = winner ? tc1 : tc0;
          count_d = '0;
        end
      RUN:
        if (!req[owner_q]) begin
          state_d = IDLE;
          count_d = '0;
        end else if (!hold && tick) begin
          if (count_q == tc_q) state_d = DONE;
          else count_d = count_q + WIDTH'(1);
        end
      DONE: begin
        state_d = IDLE;
        last_d  = owner_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    gnt   = state_q == RUN ? owner_oh(owner_q) : '0;
    done  = state_q == DONE ? owner_oh(owner_q) : '0;
    busy  = state_q != IDLE;
    count = count_q;
  end
endmodule

// File: tb/tb_counter_scheduler.sv
// tb_counter_scheduler: directed and randomized checks of counter_scheduler against a behavioural model
module tb_counter_scheduler;
  localparam int W = 8;
`ifdef COUNTER_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif
  logic clk = 0, reset = 0, hold = 0;
  logic [1:0] req = 0;
  logic [W-1:0] tc0 = 0, tc1 = 0;
  logic [1:0] gnt, done;
  logic busy;
  logic [W-1:0] count;
  int total = 0, bad = 0;
  int m_own, m_done, m_last, m_pre, m_cnt, m_tc;
  always #5 clk = ~clk;
  counter_scheduler #(.WIDTH(W), .PRESCALE(4)) dut (
    .clk(clk), .reset(reset), .req(req), .tc0(tc0), .tc1(tc1), .hold(hold),
    .gnt(gnt), .busy(busy), .count(count), .done(done)
  );
  task automatic m_reset;
    m_own = -1; m_done = -1; m_last = 1; m_pre = 0; m_cnt = 0; m_tc = 0;
  endtask
  task automatic m_edge;
    if (m_done >= 0) begin
      m_last = m_done;
      m_done = -1;
    end else if (m_own < 0) begin
      if (req != 0) begin
        m_own = (req == 2'b11) ? 1 - m_last : (req == 2'b10 ? 1 : 0);
        m_tc  = m_own == 1 ? int'(tc1) : int'(tc0);
        m_cnt = 0;
        m_pre = 0;
      end
    end else if (!req[m_own]) begin
      m_own = -1;
      m_cnt = 0;
    end else if (!hold) begin
      if (m_pre == PS - 1) begin
        m_pre = 0;
        if (m_cnt == m_tc) begin
          m_done = m_own;
          m_own  = -1;
        end else m_cnt++;
      end else m_pre++;
    end
  endtask
  function automatic logic [W+4:0] m_vec();
    logic [1:0] g, d;
    g = (m_own < 0) ? 2'b00 : (m_own == 1 ? 2'b10 : 2'b01);
    d = (m_done < 0) ? 2'b00 : (m_done == 1 ? 2'b10 : 2'b01);
    return {g, (m_own >= 0 || m_done >= 0), d, W'(m_cnt)};
  endfunction
  task automatic cyc;
    @(posedge clk);
    m_edge();
    #1;
  endtask
  task automatic do_reset;
    reset = 0; req = 0; hold = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
  endtask
  task automatic wait_done(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      cyc();
      if (done != 0) begin
        n = i;
        break;
      end
    end
  endtask
  task automatic test_reset;
    do_reset();
    total++; if ({gnt, busy, done, count} !== '0) begin bad++; $display("FAIL reset_state got=%h want=0", {gnt, busy, done, count}); end
    req = 2'b01; tc0 = 20;
    cyc(); repeat (3) cyc();
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL reset_prerun_gnt got=%b want=01", gnt); end
    #2 reset = 0;
    #1;
    total++; if ({gnt, busy, done, count} !== '0) begin bad++; $display("FAIL reset_async got=%h want=0", {gnt, busy, done, count}); end
    m_reset();
    @(posedge clk);
    #1;
    reset = 1; req = 2'b11; tc0 = 1; tc1 = 1;
    cyc();
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL reset_first_grant got=%b want=01", gnt); end
    req = 0;
    cyc();
  endtask
  task automatic test_single;
    tc0 = 3; req = 2'b01;
    cyc();
    tc0 = 200;
    total++; if ({gnt, count} !== {2'b01, W'(0)}) begin bad++; $display("FAIL single_grant got=%h want=%h", {gnt, count}, {2'b01, W'(0)}); end
    for (int k = 1; k <= 3; k++) begin
      repeat (PS) cyc();
      total++; if ({done, count} !== {2'b00, W'(k)}) begin bad++; $display("FAIL single_count k=%0d got=%h want=%h", k, {done, count}, {2'b00, W'(k)}); end
    end
    repeat (PS) cyc();
    total++; if ({gnt, busy, done, count} !== {2'b00, 1'b1, 2'b01, W'(3)}) begin bad++; $display("FAIL single_done got=%h want=%h", {gnt, busy, done, count}, {2'b00, 1'b1, 2'b01, W'(3)}); end
    req = 0;
    cyc();
    total++; if ({busy, done} !== 3'b000) begin bad++; $display("FAIL single_idle got=%b want=000", {busy, done}); end
  endtask
  task automatic test_contention;
    int n;
    do_reset();
    req = 2'b11; tc0 = 2; tc1 = 1;
    cyc();
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL cont_first got=%b want=01", gnt); end
    wait_done(100, n);
    total++; if (n !== 3 * PS || done !== 2'b01) begin bad++; $display("FAIL cont_done0 got=%0d/%b want=%0d/01", n, done, 3 * PS); end
    req = 2'b10;
    cyc();
    total++; if ({gnt, busy} !== 3'b000) begin bad++; $display("FAIL cont_gap got=%b want=000", {gnt, busy}); end
    cyc();
    total++; if (gnt !== 2'b10) begin bad++; $display("FAIL cont_second got=%b want=10", gnt); end
    wait_done(100, n);
    total++; if (n !== 2 * PS || done !== 2'b10) begin bad++; $display("FAIL cont_done1 got=%0d/%b want=%0d/10", n, done, 2 * PS); end
    req = 0;
    cyc();
  endtask
  task automatic test_hold_tc0;
    int n;
    req = 2'b01; tc0 = 5;
    cyc();
    repeat (2 * PS) cyc();
    total++; if (count !== W'(2)) begin bad++; $display("FAIL hold_pre got=%0d want=2", count); end
    hold = 1;
    repeat (3) cyc();
    total++; if (count !== W'(2)) begin bad++; $display("FAIL hold_frozen got=%0d want=2", count); end
    hold = 0;
    wait_done(100, n);
    total++; if (n !== 4 * PS || done !== 2'b01) begin bad++; $display("FAIL hold_done got=%0d/%b want=%0d/01", n, done, 4 * PS); end
    req = 0;
    cyc();
    req = 2'b10; tc1 = 0;
    cyc();
    total++; if ({gnt, count} !== {2'b10, W'(0)}) begin bad++; $display("FAIL tc0_grant got=%h want=%h", {gnt, count}, {2'b10, W'(0)}); end
    wait_done(100, n);
    total++; if (n !== PS || done !== 2'b10) begin bad++; $display("FAIL tc0_done got=%0d/%b want=%0d/10", n, done, PS); end
    req = 0;
    cyc();
  endtask
  task automatic test_abort;
    int n;
    do_reset();
    req = 2'b11; tc0 = 10; tc1 = 7;
    cyc();
    total++; if (gnt !== 2'b01) begin bad++; $display("FAIL abort_grant got=%b want=01", gnt); end
    repeat (4 * PS) cyc();
    total++; if (count !== W'(4)) begin bad++; $display("FAIL abort_pre got=%0d want=4", count); end
    req = 2'b10;
    cyc();
    total++; if ({gnt, busy, done, count} !== '0) begin bad++; $display("FAIL abort_clear got=%h want=0", {gnt, busy, done, count}); end
    cyc();
    total++; if (gnt !== 2'b10) begin bad++; $display("FAIL abort_next got=%b want=10", gnt); end
    wait_done(200, n);
    total++; if (n !== 8 * PS || done !== 2'b10) begin bad++; $display("FAIL abort_done1 got=%0d/%b want=%0d/10", n, done, 8 * PS); end
    req = 0;
    cyc();
  endtask
  task automatic test_back_to_back;
    int n;
    req = 2'b01; tc0 = 1;
    cyc();
    wait_done(100, n);
    total++; if (n !== 2 * PS || done !== 2'b01) begin bad++; $display("FAIL b2b_done got=%0d/%b want=%0d/01", n, done, 2 * PS); end
    cyc();
    total++; if ({gnt, busy} !== 3'b000) begin bad++; $display("FAIL b2b_gap got=%b want=000", {gnt, busy}); end
    cyc();
    total++; if ({gnt, count} !== {2'b01, W'(0)}) begin bad++; $display("FAIL b2b_regrant got=%h want=%h", {gnt, count}, {2'b01, W'(0)}); end
    req = 0;
    cyc();
  endtask
  task automatic test_tc255;
    int n;
    req = 2'b01; tc0 = 255;
    cyc();
    wait_done(300 * PS, n);
    total++; if (n !== 256 * PS || {done, count} !== {2'b01, W'(255)}) begin bad++; $display("FAIL tc255 got=%0d/%h want=%0d/%h", n, {done, count}, 256 * PS, {2'b01, W'(255)}); end
    req = 0;
    cyc();
  endtask
  task automatic test_random;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) req = 2'($urandom_range(3));
      hold = $urandom_range(5) == 0;
      tc0 = W'($urandom_range(12));
      tc1 = W'($urandom_range(12));
      cyc();
      total++; if ({gnt, busy, done, count} !== m_vec()) begin bad++; $display("FAIL random i=%0d got=%h want=%h", i, {gnt, busy, done, count}, m_vec()); end
    end
    req = 0; hold = 0;
    repeat (3) cyc();
  endtask
  initial begin
    test_reset();
    test_single();
    test_contention();
    test_hold_tc0();
    test_abort();
    test_back_to_back();
    test_tc255();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
